risc_stack: RTL and testbench

Parametrised hardware stack for the RISC core's PUSH/POP instructions. It generalises the fixed 8-bit, implicit stack into a configurable WIDTH × DEPTH LIFO with occupancy count, full/empty status, simultaneous push+pop (replace-top) and sticky overflow/underflow error flags. It sits beside the register file: the decode stage drives `push`/`pop` from the PUSH/POP opcodes, `din` from `$rd`, and the writeback stage takes `dout` into `$rd` on POP.

---
 rtl/risc_pkg.sv | 17 +
 rtl/risc_stack_mem.sv | 33 +++
 rtl/risc_stack.sv | 119 +++++++++++
 tb/tb_risc_stack.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared RISC core definitions: stack sizing and the stack operation decode.
package risc_pkg;

    localparam int stack_depth = 16;

    typedef enum logic [1:0] {STK_NONE, STK_PUSH, STK_POP, STK_REPL} e_stack_op;

    function automatic e_stack_op stack_decode(input logic push, input logic pop);
        case ({push, pop})
            2'b10:   return STK_PUSH;
            2'b01:   return STK_POP;
            2'b11:   return STK_REPL;
            default: return STK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/risc_stack_mem.sv
// WIDTH x DEPTH register array: one synchronous write port, combinational top read
// port, plus a peek read port when RISC_STACK_PEEK_EN is defined.
module risc_stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
`ifdef RISC_STACK_PEEK_EN
    ,
    input  logic [$clog2(DEPTH)-1:0] peek_addr,
    output logic [WIDTH-1:0]         peek_rdata
`endif
);

    // Contents are intentionally not reset; the pointer alone defines validity.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

`ifdef RISC_STACK_PEEK_EN
    assign peek_rdata = mem_q[peek_addr];
`endif

endmodule

// File: rtl/risc_stack.sv
// Parametrised LIFO for PUSH/POP with replace-top and sticky overflow/underflow.
// Optional debug peek port enabled by defining RISC_STACK_PEEK_EN.
module risc_stack
    import risc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = stack_depth
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    input  logic                       err_clr,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
`ifdef RISC_STACK_PEEK_EN
    ,
    input  logic [$clog2(DEPTH)-1:0]   peek_idx,
    output logic [WIDTH-1:0]           peek_data
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] top_rdata;
    e_stack_op        op;

    assign op      = stack_decode(push, pop);
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign top_idx = AW'(count_q - CW'(1));

    always_comb begin
        count_d = count_q;
        we      = 1'b0;
        waddr   = top_idx;
        // A fresh error in the same cycle outranks err_clr.
        ovf_d   = ovf_q & ~err_clr;
        udf_d   = udf_q & ~err_clr;
        case (op)
            STK_PUSH: begin
                if (!full) begin
                    we      = 1'b1;
                    waddr   = AW'(count_q);
                    count_d = count_q + CW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
            STK_POP: begin
                if (!empty) count_d = count_q - CW'(1);
                else        udf_d   = 1'b1;
            end
            STK_REPL: begin
                we = 1'b1;
                if (empty) begin
                    waddr   = '0;
                    count_d = CW'(1);
                    udf_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

`ifdef RISC_STACK_PEEK_EN
    logic [WIDTH-1:0] peek_rdata;
    logic [AW-1:0]    peek_addr;
    assign peek_addr = AW'(count_q - CW'(1) - CW'(peek_idx));
`endif

    risc_stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (we & ~rst),
        .waddr (waddr),
        .wdata (din),
        .raddr (top_idx),
        .rdata (top_rdata)
`ifdef RISC_STACK_PEEK_EN
        ,
        .peek_addr  (peek_addr),
        .peek_rdata (peek_rdata)
`endif
    );

    assign dout      = empty ? '0 : top_rdata;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

`ifdef RISC_STACK_PEEK_EN
    assign peek_data = (CW'(peek_idx) < count_q) ? peek_rdata : '0;
`endif

endmodule

// File: tb/tb_risc_stack.sv
// Self-checking bench for risc_stack (WIDTH=8, DEPTH=4): directed vector table,
// hand sequences and randomized traffic against a queue-based reference model.
module tb_risc_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst, push, pop, err_clr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             empty, full, overflow, underflow;
    logic [2:0]       count;
    logic [1:0]       peek_idx = '0;
`ifdef RISC_STACK_PEEK_EN
    logic [WIDTH-1:0] peek_data;
`endif

    int checks = 0;
    int errors = 0;

    risc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .din       (din),
        .err_clr   (err_clr),
        .dout      (dout),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef RISC_STACK_PEEK_EN
        ,
        .peek_idx  (peek_idx),
        .peek_data (peek_data)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the stack is a queue whose back is the top.
    logic [WIDTH-1:0] mq[$];
    logic             m_ovf, m_udf;

    task automatic model_step(input logic r, p, o, c, input logic [WIDTH-1:0] d);
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            logic nov, nud;
            nov = m_ovf && !c;
            nud = m_udf && !c;
            if (p && !o) begin
                if (mq.size() < DEPTH) mq.push_back(d);
                else nov = 1'b1;
            end else if (!p && o) begin
                if (mq.size() > 0) void'(mq.pop_back());
                else nud = 1'b1;
            end else if (p && o) begin
                if (mq.size() > 0) mq[mq.size()-1] = d;
                else begin
                    mq.push_back(d);
                    nud = 1'b1;
                end
            end
            m_ovf = nov;
            m_udf = nud;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_top();
        return (mq.size() > 0) ? int'(mq[mq.size()-1]) : 0;
    endfunction

    function automatic int m_peek(input int idx);
        return (idx < mq.size()) ? int'(mq[mq.size()-1-idx]) : 0;
    endfunction

    task automatic chk_model();
        chk("count", int'(count), mq.size());
        chk("dout", int'(dout), m_top());
        chk("empty", int'(empty), int'(mq.size() == 0));
        chk("full", int'(full), int'(mq.size() == DEPTH));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("underflow", int'(underflow), int'(m_udf));
`ifdef RISC_STACK_PEEK_EN
        chk("peek_data", int'(peek_data), m_peek(int'(peek_idx)));
`endif
    endtask

    task automatic step(input logic r, p, o, c, input logic [WIDTH-1:0] d);
        @(negedge clk);
        rst = r; push = p; pop = o; err_clr = c; din = d;
        @(posedge clk);
        model_step(r, p, o, c, d);
        #1;
        chk_model();
    endtask

    typedef struct {
        logic             rst, push, pop, clr;
        logic [WIDTH-1:0] din;
        int               ecnt;
        logic [WIDTH-1:0] edout;
        logic             eovf, eudf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, p, o, c, input logic [7:0] d,
                                input int ec, input logic [7:0] ed, input logic eo, eu);
        vec_t v;
        v.rst = r; v.push = p; v.pop = o; v.clr = c; v.din = d;
        v.ecnt = ec; v.edout = ed; v.eovf = eo; v.eudf = eu;
        return v;
    endfunction

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0; din = '0;
        m_ovf = 1'b0; m_udf = 1'b0;

        //            rst push pop clr din    cnt dout  ovf udf
        tbl.push_back(mk(0, 1, 0, 0, 8'h11, 1, 8'h11, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h22, 2, 8'h22, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h33, 3, 8'h33, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 8'h00, 2, 8'h22, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 8'h00, 1, 8'h11, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'hA0, 1, 8'hA0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'hA1, 2, 8'hA1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'hA2, 3, 8'hA2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'hA3, 4, 8'hA3, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'hFF, 4, 8'hA3, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'h00, 4, 8'hA3, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 8'h00, 0, 8'h00, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h05, 1, 8'h05, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 8'h77, 1, 8'h77, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h01, 2, 8'h01, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h02, 3, 8'h02, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h03, 4, 8'h03, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 8'h88, 4, 8'h88, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 8'h09, 1, 8'h09, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 8'h00, 1, 8'h09, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h01, 1, 8'h01, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h02, 2, 8'h02, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h03, 3, 8'h03, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 8'h44, 0, 8'h00, 0, 0));

        // Reset state
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].push, tbl[i].pop, tbl[i].clr, tbl[i].din);
            chk($sformatf("vec%0d.count", i), int'(count), tbl[i].ecnt);
            chk($sformatf("vec%0d.dout", i), int'(dout), int'(tbl[i].edout));
            chk($sformatf("vec%0d.ovf", i), int'(overflow), int'(tbl[i].eovf));
            chk($sformatf("vec%0d.udf", i), int'(underflow), int'(tbl[i].eudf));
        end

`ifdef RISC_STACK_PEEK_EN
        step(0, 1, 0, 0, 8'h10);
        step(0, 1, 0, 0, 8'h20);
        step(0, 1, 0, 0, 8'h30);
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
        peek_idx = 2'd0; #1; chk("peek0", int'(peek_data), 8'h30);
        peek_idx = 2'd1; #1; chk("peek1", int'(peek_data), 8'h20);
        peek_idx = 2'd2; #1; chk("peek2", int'(peek_data), 8'h10);
        peek_idx = 2'd3; #1; chk("peek3", int'(peek_data), 8'h00);
`endif

        // Random traffic, biased toward push/pop with rare resets and clears.
        for (int n = 0; n < 400; n++) begin
            logic r, p, o, c;
            r = ($urandom_range(0, 59) == 0);
            p = ($urandom_range(0, 99) < 55);
            o = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 9) == 0);
            peek_idx = 2'($urandom_range(0, 3));
            step(r, p, o, c, 8'($urandom));
        end

        @(negedge clk);
        push = 1'b0; pop = 1'b0; err_clr = 1'b0; rst = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
